// File: rtl/ultrasonic_pkg.sv
// Shared types, constants and defaults for the ultrasonic ranging scheduler.
package ultrasonic_pkg;

   localparam int unsigned MAX_CH  = 8;
   localparam int unsigned CH_W    = 3;
   localparam int unsigned CNT_W   = 17;
   localparam int unsigned DIST_W  = 16;

   // Echo round trip time per centimetre of distance.
   localparam int unsigned US_PER_CM = 58;

   localparam logic [DIST_W-1:0] DIST_TIMEOUT = 16'hFFFF;
   localparam logic [DIST_W-1:0] DIST_SAT     = 16'hFFFE;

   localparam int unsigned DEF_N_CH       = 4;
   localparam int unsigned DEF_CLK_HZ     = 100_000_000;
   localparam int unsigned DEF_TRIG_US    = 10;
   localparam int unsigned DEF_RISE_TO_US = 5_000;
   localparam int unsigned DEF_FALL_TO_US = 30_000;
   localparam int unsigned DEF_GAP_US     = 60_000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SELECT    = 3'd1,
      ST_TRIG      = 3'd2,
      ST_WAIT_RISE = 3'd3,
      ST_WAIT_FALL = 3'd4,
      ST_GAP       = 3'd5
   } state_e;

   typedef struct packed {
      logic [DIST_W-1:0] cm;
      logic [CH_W-1:0]   ch;
      logic              err;
   } dist_s;

   // Next set mask bit strictly after cur, wrapping over n_ch channels; cur if none set.
   function automatic logic [CH_W-1:0] next_ch(input logic [MAX_CH-1:0] mask,
                                               input logic [CH_W-1:0]   cur,
                                               input int unsigned       n_ch);
      logic [CH_W-1:0] res;
      logic            found;
      int unsigned     idx;
      res   = cur;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_CH; i++) begin
         idx = (32'(cur) + i) % n_ch;
         if (!found && (i <= n_ch) && mask[CH_W'(idx)]) begin
            res   = CH_W'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/usec_tick.sv
// One-microsecond strobe generator with a synchronous phase restart.
module usec_tick #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   output logic tick_c
);

   localparam int unsigned DIV  = CLK_HZ / 1_000_000;
   localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] pcnt;

   // Prescaler; clr realigns the microsecond grid to the current clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt <= '0;
      end else if (clr || (pcnt == LAST)) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   assign tick_c = (pcnt == LAST);

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 scheduler: one shared trigger/echo timing engine for N_CH sensors.
module ultrasonic_scheduler
   import ultrasonic_pkg::*;
#(
   parameter int unsigned N_CH       = DEF_N_CH,
   parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
   parameter int unsigned TRIG_US    = DEF_TRIG_US,
   parameter int unsigned RISE_TO_US = DEF_RISE_TO_US,
   parameter int unsigned FALL_TO_US = DEF_FALL_TO_US,
   parameter int unsigned GAP_US     = DEF_GAP_US
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [N_CH-1:0]   ch_mask,
   input  logic [N_CH-1:0]   echo,
   output logic [N_CH-1:0]   trig,
   output logic [DIST_W-1:0] dist_cm,
   output logic [CH_W-1:0]   dist_ch,
   output logic              dist_err,
   output logic              dist_valid,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
   localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TO_US - 1);
   localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_TO_US - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_US - 1);

   state_e            state_q, state_nxt;
   logic [CH_W-1:0]   cur, ptr_nxt;
   logic [N_CH-1:0]   sync1, sync2;
   logic              sel_prev;
   logic [CNT_W-1:0]  us_cnt;
   dist_s             res_q;

   logic              tick_c;
   logic              cnt_clr_c;
   logic              res_load_c;
   dist_s             res_c;
   logic [MAX_CH-1:0] sync_ext_c;
   logic [MAX_CH-1:0] mask_ext_c;
   logic              mask_any_c;
   logic              sel_now_c;
   logic              rise_c;
   logic              fall_c;
   logic [CNT_W-1:0]  cnt_inc_c;
   logic [CNT_W-1:0]  width_c;
   logic [CNT_W-1:0]  cm_raw_c;
   logic [DIST_W-1:0] cm_c;

   usec_tick #(
      .CLK_HZ (CLK_HZ)
   ) u_usec_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr_c),
      .tick_c  (tick_c)
   );

   assign sync_ext_c = MAX_CH'(sync2);
   assign mask_ext_c = MAX_CH'(ch_mask);
   assign mask_any_c = |ch_mask;
   assign sel_now_c  = sync_ext_c[cur];
   assign rise_c     = sel_now_c & ~sel_prev;
   assign fall_c     = ~sel_now_c & sel_prev;

   // Saturating increment; the width includes a tick landing on the edge clock.
   assign cnt_inc_c = (us_cnt == CNT_MAX) ? us_cnt : us_cnt + CNT_W'(1);
   assign width_c   = tick_c ? cnt_inc_c : us_cnt;
   assign cm_raw_c  = width_c / CNT_W'(US_PER_CM);
   assign cm_c      = (cm_raw_c > CNT_W'(DIST_SAT)) ? DIST_SAT : DIST_W'(cm_raw_c);

   // Every state change restarts the microsecond counter and its prescaler.
   assign cnt_clr_c = (state_nxt != state_q);

   // Echo synchronisers and previous sample of the selected channel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= '0;
         sync2    <= '0;
         sel_prev <= 1'b0;
      end else begin
         sync1    <= echo;
         sync2    <= sync1;
         sel_prev <= sel_now_c;
      end
   end

   // Interval counter in whole microseconds, saturating.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         us_cnt <= '0;
      end else if (cnt_clr_c) begin
         us_cnt <= '0;
      end else if (tick_c) begin
         us_cnt <= cnt_inc_c;
      end
   end

   // Next-state, channel pointer and result decode; edges take priority over timeouts.
   always_comb begin
      state_nxt  = state_q;
      ptr_nxt    = cur;
      res_load_c = 1'b0;
      res_c      = '{cm: DIST_TIMEOUT, ch: cur, err: 1'b1};
      case (state_q)
         ST_IDLE: begin
            if (enable && mask_any_c) state_nxt = ST_SELECT;
         end
         ST_SELECT: begin
            if (mask_any_c) begin
               ptr_nxt   = next_ch(mask_ext_c, cur, N_CH);
               state_nxt = ST_TRIG;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_TRIG: begin
            if (tick_c && (us_cnt >= TRIG_LAST)) state_nxt = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: begin
            if (rise_c) begin
               state_nxt = ST_WAIT_FALL;
            end else if (tick_c && (us_cnt >= RISE_LAST)) begin
               res_load_c = 1'b1;
               state_nxt  = ST_GAP;
            end
         end
         ST_WAIT_FALL: begin
            if (fall_c) begin
               res_load_c = 1'b1;
               res_c.cm   = cm_c;
               res_c.err  = 1'b0;
               state_nxt  = ST_GAP;
            end else if (tick_c && (us_cnt >= FALL_LAST)) begin
               res_load_c = 1'b1;
               state_nxt  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tick_c && (us_cnt >= GAP_LAST)) begin
               state_nxt = (enable && mask_any_c) ? ST_SELECT : ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (!enable) begin
         state_nxt  = ST_IDLE;
         ptr_nxt    = cur;
         res_load_c = 1'b0;
      end
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cur        <= CH_W'(N_CH - 1);
         trig       <= '0;
         busy       <= 1'b0;
         dist_valid <= 1'b0;
         res_q      <= '0;
      end else begin
         state_q    <= state_nxt;
         cur        <= ptr_nxt;
         trig       <= (state_nxt == ST_TRIG) ? (N_CH'(1) << ptr_nxt) : '0;
         busy       <= (state_nxt != ST_IDLE);
         dist_valid <= res_load_c;
         if (res_load_c) res_q <= res_c;
      end
   end

   assign dist_cm  = res_q.cm;
   assign dist_ch  = res_q.ch;
   assign dist_err = res_q.err;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Scoreboard bench for ultrasonic_scheduler with scaled-down timing parameters.
module tb_ultrasonic_scheduler;

   localparam int unsigned N_CH       = 4;
   localparam int unsigned CLK_HZ     = 2_000_000;
   localparam int unsigned DIV        = 2;
   localparam int unsigned TRIG_US    = 10;
   localparam int unsigned RISE_TO_US = 200;
   localparam int unsigned FALL_TO_US = 1500;
   localparam int unsigned GAP_US     = 300;
   localparam int          WAIT_MAX   = 20000;

   typedef struct packed {
      logic [15:0] cm;
      logic [2:0]  ch;
      logic        err;
   } res_t;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic [N_CH-1:0] ch_mask;
   logic [N_CH-1:0] echo;
   logic [N_CH-1:0] trig;
   logic [15:0]     dist_cm;
   logic [2:0]      dist_ch;
   logic            dist_err;
   logic            dist_valid;
   logic            busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   res_t exp_res_q[$];
   int   exp_trig_q[$];

   ultrasonic_scheduler #(
      .N_CH       (N_CH),
      .CLK_HZ     (CLK_HZ),
      .TRIG_US    (TRIG_US),
      .RISE_TO_US (RISE_TO_US),
      .FALL_TO_US (FALL_TO_US),
      .GAP_US     (GAP_US)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .ch_mask    (ch_mask),
      .echo       (echo),
      .trig       (trig),
      .dist_cm    (dist_cm),
      .dist_ch    (dist_ch),
      .dist_err   (dist_err),
      .dist_valid (dist_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic res_t mk_res(input int cm, input int ch, input bit err);
      res_t r;
      r.cm  = 16'(cm);
      r.ch  = 3'(ch);
      r.err = err;
      return r;
   endfunction

   // Result monitor: every dist_valid pulse must match the oldest expected result.
   res_t mon_exp;
   always @(negedge clk) begin
      if (reset_n && dist_valid) begin
         if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual ch=%0d cm=%0h err=%0b required=none",
                     dist_ch, dist_cm, dist_err);
         end else begin
            mon_exp = exp_res_q.pop_front();
            check("dist_cm", 32'(dist_cm), 32'(mon_exp.cm));
            check("dist_ch", 32'(dist_ch), 32'(mon_exp.ch));
            check("dist_err", 32'(dist_err), 32'(mon_exp.err));
         end
      end
   end

   // Trigger monitor: one-hot lines, expected channel order and pulse width.
   bit in_pulse = 1'b0;
   int rise_cyc;
   int pulse_ch;
   int exp_ch;
   always @(negedge clk) begin
      check("trig_onehot", 32'($countones(trig) <= 1), 32'd1);
      if (!reset_n) begin
         in_pulse = 1'b0;
      end else if (!in_pulse && (trig != '0)) begin
         in_pulse = 1'b1;
         rise_cyc = cyc;
         pulse_ch = 0;
         for (int i = 0; i < int'(N_CH); i++) if (trig[i]) pulse_ch = i;
         if (exp_trig_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_trig actual ch=%0d required=none", pulse_ch);
         end else begin
            exp_ch = exp_trig_q.pop_front();
            check("trig_ch", 32'(pulse_ch), 32'(exp_ch));
         end
      end else if (in_pulse && (trig == '0)) begin
         in_pulse = 1'b0;
         check("trig_width", 32'(cyc - rise_cyc), 32'(TRIG_US * DIV));
      end
   end

   task automatic wait_trig(input int ch, input logic lvl);
      int n;
      n = 0;
      while (trig[2'(ch)] !== lvl) begin
         @(negedge clk);
         n++;
         if (n > WAIT_MAX) begin
            checks++;
            errors++;
            $display("FAIL wait_trig ch=%0d actual=timeout required=level %0b", ch, lvl);
            return;
         end
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (dist_valid !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > WAIT_MAX) begin
            checks++;
            errors++;
            $display("FAIL wait_valid actual=timeout required=dist_valid");
            return;
         end
      end
   endtask

   task automatic pulse_echo(input int ch, input int us);
      echo[2'(ch)] = 1'b1;
      repeat (us * int'(DIV)) @(negedge clk);
      echo[2'(ch)] = 1'b0;
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   int t0;
   int active;
   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      ch_mask = '0;
      echo    = '0;
      repeat (3) @(negedge clk);
      check("rst_trig", 32'(trig), 32'd0);
      check("rst_dist_cm", 32'(dist_cm), 32'd0);
      check("rst_dist_ch", 32'(dist_ch), 32'd0);
      check("rst_dist_err", 32'(dist_err), 32'd0);
      check("rst_dist_valid", 32'(dist_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;

      // Enabled with an empty mask: the engine stays idle.
      enable = 1'b1;
      active = 0;
      repeat (2000) begin
         @(negedge clk);
         if (busy || (trig != '0)) active++;
      end
      check("empty_mask_idle", 32'(active), 32'd0);

      // Channel 0, 580 us echo -> 10 cm; then channel 2 after the gap.
      exp_trig_q.push_back(0);
      ch_mask = 4'b0101;
      wait_trig(0, 1'b1);
      wait_trig(0, 1'b0);
      check("busy_meas", 32'(busy), 32'd1);
      repeat (20) @(negedge clk);
      exp_res_q.push_back(mk_res(10, 0, 1'b0));
      pulse_echo(0, 580);
      wait_valid();
      t0 = cyc;
      exp_trig_q.push_back(2);
      wait_trig(2, 1'b1);
      check("gap_len", 32'(cyc - t0), 32'(GAP_US * DIV + 1));

      // Channel 2, no echo -> rise timeout.
      wait_trig(2, 1'b0);
      t0 = cyc;
      exp_res_q.push_back(mk_res(16'hFFFF, 2, 1'b1));
      wait_valid();
      check("rise_timeout_len", 32'(cyc - t0), 32'(RISE_TO_US * DIV));

      // Channel 0, 1160 us echo while echo[1] chatters -> 20 cm, nothing from channel 1.
      @(negedge clk);
      ch_mask = 4'b0111;
      exp_trig_q.push_back(0);
      wait_trig(0, 1'b1);
      wait_trig(0, 1'b0);
      exp_res_q.push_back(mk_res(20, 0, 1'b0));
      echo[1] = 1'b1;
      repeat (10) @(negedge clk);
      echo[1] = 1'b0;
      repeat (10) @(negedge clk);
      echo[0] = 1'b1;
      for (int i = 0; i < 1160 * int'(DIV); i++) begin
         @(negedge clk);
         if ((i % 100) == 0) echo[1] = ~echo[1];
      end
      echo[0] = 1'b0;
      echo[1] = 1'b0;
      wait_valid();

      // Channel 1, echo stuck high -> fall timeout; its mask bit drops mid-measurement.
      exp_trig_q.push_back(1);
      wait_trig(1, 1'b1);
      wait_trig(1, 1'b0);
      exp_res_q.push_back(mk_res(16'hFFFF, 1, 1'b1));
      repeat (5) @(negedge clk);
      echo[1] = 1'b1;
      t0 = cyc;
      repeat (100) @(negedge clk);
      ch_mask = 4'b0101;
      wait_valid();
      check("fall_timeout_len", 32'(cyc - t0), 32'(FALL_TO_US * DIV + 3));
      @(negedge clk);
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_trig", 32'(trig), 32'd0);
      while ((cyc - t0) < 3400) @(negedge clk);
      echo[1] = 1'b0;

      // Channel 2, enable dropped while the echo is high.
      exp_trig_q.push_back(2);
      wait_trig(2, 1'b1);
      wait_trig(2, 1'b0);
      repeat (4) @(negedge clk);
      echo[2] = 1'b1;
      repeat (200) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("dis_busy", 32'(busy), 32'd0);
      check("dis_trig", 32'(trig), 32'd0);
      check("dis_valid", 32'(dist_valid), 32'd0);
      check("dis_hold_cm", 32'(dist_cm), 32'hFFFF);
      check("dis_hold_ch", 32'(dist_ch), 32'd1);
      check("dis_hold_err", 32'(dist_err), 32'd1);
      repeat (50) @(negedge clk);
      echo[2] = 1'b0;
      repeat (50) @(negedge clk);

      // Reset pulsed during a trigger pulse on channel 0.
      exp_trig_q.push_back(0);
      enable = 1'b1;
      wait_trig(0, 1'b1);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rstmid_trig", 32'(trig), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_cm", 32'(dist_cm), 32'd0);
      check("rstmid_ch", 32'(dist_ch), 32'd0);
      check("rstmid_err", 32'(dist_err), 32'd0);
      check("rstmid_valid", 32'(dist_valid), 32'd0);
      repeat (2) @(negedge clk);

      // After reset channel 0 is first again; truncating division at 115 us and 57 us.
      exp_trig_q.push_back(0);
      reset_n = 1'b1;
      wait_trig(0, 1'b1);
      wait_trig(0, 1'b0);
      exp_res_q.push_back(mk_res(1, 0, 1'b0));
      repeat (3) @(negedge clk);
      pulse_echo(0, 115);
      wait_valid();
      exp_trig_q.push_back(2);
      wait_trig(2, 1'b1);
      wait_trig(2, 1'b0);
      exp_res_q.push_back(mk_res(0, 2, 1'b0));
      repeat (3) @(negedge clk);
      pulse_echo(2, 57);
      wait_valid();
      @(negedge clk);
      enable = 1'b0;
      repeat (20) @(negedge clk);
      check("end_busy", 32'(busy), 32'd0);
      check("res_queue_empty", 32'(exp_res_q.size()), 32'd0);
      check("trig_queue_empty", 32'(exp_trig_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
